// File: rtl/fx2_slave_fifo_emu.sv
// FX2 slave-FIFO responder: EP2 (and optional EP4) are sources read by the master, EP6 is a sink.
// Latency: pin strobe edge to FIFO pointer update 3 clk (2-FF sync + edge stage), to flags 4 clk.
// Backpressure: host pushes gated by registered ep*_in_ready, EP6 is FWFT valid/ready, master errors sticky.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   usb_*               - slave-FIFO pins driven by the external master; usb_fd is bidirectional
//   usb_flaga/b/c       - EP2 not empty / EP4 not empty / EP6 not full (registered)
//   ep2_in_*, ep4_in_*  - host-side valid/ready streams feeding the source FIFOs
//   ep6_out_*           - host-side valid/ready stream draining the sink FIFO
//   ep2_underflow, ep6_overflow - sticky master protocol errors
// Optional build macro: FX2_EMU_EP4_EN enables the EP4 source FIFO at fifoaddr 01.

module fx2_emu_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [AW:0]   count_o,
    output logic [AW:0]   count_nxt_o
);
    localparam logic [AW:0]   FULL  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT1  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR1  = AW'(1);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] last_q;
    logic          push_ok, pop_ok;

    // Push on full and pop on empty are dropped here; the parent flags the error.
    assign push_ok = push_i && (count_q != FULL);
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CNT1;
        else if (!push_ok && pop_ok)
            count_d = count_q - CNT1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR1;
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR1;
                last_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_dat_i;
    end

    // An empty FIFO keeps presenting the word most recently read out.
    assign head_o      = (count_q == '0) ? last_q : mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;
endmodule

module fx2_slave_fifo_emu #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    usb_fifoaddr,
    input  logic          usb_slcs,
    input  logic          usb_sloe,
    input  logic          usb_slrd,
    input  logic          usb_slwr,
    inout  wire  [DW-1:0] usb_fd,
    output logic          usb_flaga,
    output logic          usb_flagb,
    output logic          usb_flagc,
    input  logic [DW-1:0] ep2_in_data,
    input  logic          ep2_in_valid,
    output logic          ep2_in_ready,
    input  logic [DW-1:0] ep4_in_data,
    input  logic          ep4_in_valid,
    output logic          ep4_in_ready,
    output logic [DW-1:0] ep6_out_data,
    output logic          ep6_out_valid,
    input  logic          ep6_out_ready,
    output logic          ep2_underflow,
    output logic          ep6_overflow
);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic {ST_IDLE, ST_LOW} strobe_st_e;

    // Synchronizer chains: index 0 = s1, 1 = s2, 2 = s3.
    logic [2:0]          slcs_q, slrd_q, slwr_q;
    logic [1:0]          sloe_q;
    logic [2:0][1:0]     addr_q;
    logic [2:0][DW-1:0]  fd_q;
    strobe_st_e          rd_st_q, wr_st_q;
    logic                rd_evt, wr_evt;
    logic                ep2_pop, ep6_push, ep6_pop;
    logic [DW-1:0]       ep2_head, ep6_head;
    logic [AW:0]         ep2_cnt, ep2_cnt_nxt, ep6_cnt, ep6_cnt_nxt;
    logic                flaga_q, flagc_q, ep2_rdy_q, uf_q, of_q;
    logic                fd_drv_en;
    logic [DW-1:0]       fd_drv_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slcs_q <= '1;
            slrd_q <= '1;
            slwr_q <= '1;
            sloe_q <= '1;
            addr_q <= '0;
            fd_q   <= '0;
        end else begin
            slcs_q <= {slcs_q[1:0], usb_slcs};
            slrd_q <= {slrd_q[1:0], usb_slrd};
            slwr_q <= {slwr_q[1:0], usb_slwr};
            sloe_q <= {sloe_q[0], usb_sloe};
            addr_q <= {addr_q[1:0], usb_fifoaddr};
            fd_q   <= {fd_q[1:0], usb_fd};
        end
    end

    // Strobe trackers. A strobe dropping chip select aborts; a read is abandoned
    // whenever slwr is also low so the write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_st_q <= ST_IDLE;
            wr_st_q <= ST_IDLE;
        end else begin
            case (wr_st_q)
                ST_IDLE: if (!slwr_q[1] && !slcs_q[1]) wr_st_q <= ST_LOW;
                default: if (slwr_q[1] || slcs_q[1])   wr_st_q <= ST_IDLE;
            endcase
            case (rd_st_q)
                ST_IDLE: if (!slrd_q[1] && !slcs_q[1] && slwr_q[1]) rd_st_q <= ST_LOW;
                default: if (slrd_q[1] || slcs_q[1] || !slwr_q[1])  rd_st_q <= ST_IDLE;
            endcase
        end
    end

    // Rise seen at s2 while s3 still low. Address and data come from s3 because the
    // master may move fifoaddr in the same clock it releases the strobe.
    assign wr_evt   = (wr_st_q == ST_LOW) && !slwr_q[2] && slwr_q[1] && !slcs_q[2];
    assign rd_evt   = (rd_st_q == ST_LOW) && !slrd_q[2] && slrd_q[1] && !slcs_q[2];
    assign ep2_pop  = rd_evt && (addr_q[2] == 2'b00);
    assign ep6_push = wr_evt && (addr_q[2] == 2'b10);
    assign ep6_pop  = ep6_out_valid && ep6_out_ready;

    fx2_emu_fifo #(.DW(DW), .AW(AW)) u_ep2 (
        .clk(clk), .rst_n(rst_n),
        .push_i(ep2_in_valid && ep2_rdy_q), .push_dat_i(ep2_in_data), .pop_i(ep2_pop),
        .head_o(ep2_head), .count_o(ep2_cnt), .count_nxt_o(ep2_cnt_nxt)
    );

    fx2_emu_fifo #(.DW(DW), .AW(AW)) u_ep6 (
        .clk(clk), .rst_n(rst_n),
        .push_i(ep6_push), .push_dat_i(fd_q[2]), .pop_i(ep6_pop),
        .head_o(ep6_head), .count_o(ep6_cnt), .count_nxt_o(ep6_cnt_nxt)
    );

    // Ready is registered from the next count so it never admits a word into a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flaga_q   <= 1'b0;
            flagc_q   <= 1'b0;
            ep2_rdy_q <= 1'b0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            flaga_q   <= (ep2_cnt != '0);
            flagc_q   <= (ep6_cnt != FULL);
            ep2_rdy_q <= (ep2_cnt_nxt != FULL);
            if (ep2_pop && (ep2_cnt == '0))
                uf_q <= 1'b1;
            if (ep6_push && (ep6_cnt == FULL))
                of_q <= 1'b1;
        end
    end

    assign usb_flaga     = flaga_q;
    assign usb_flagc     = flagc_q;
    assign ep2_in_ready  = ep2_rdy_q;
    assign ep2_underflow = uf_q;
    assign ep6_overflow  = of_q;
    assign ep6_out_valid = (ep6_cnt != '0);
    assign ep6_out_data  = ep6_head;

`ifdef FX2_EMU_EP4_EN
    logic [DW-1:0] ep4_head;
    logic [AW:0]   ep4_cnt, ep4_cnt_nxt;
    logic          flagb_q, ep4_rdy_q;

    fx2_emu_fifo #(.DW(DW), .AW(AW)) u_ep4 (
        .clk(clk), .rst_n(rst_n),
        .push_i(ep4_in_valid && ep4_rdy_q), .push_dat_i(ep4_in_data),
        .pop_i(rd_evt && (addr_q[2] == 2'b01)),
        .head_o(ep4_head), .count_o(ep4_cnt), .count_nxt_o(ep4_cnt_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flagb_q   <= 1'b0;
            ep4_rdy_q <= 1'b0;
        end else begin
            flagb_q   <= (ep4_cnt != '0);
            ep4_rdy_q <= (ep4_cnt_nxt != FULL);
        end
    end

    assign usb_flagb    = flagb_q;
    assign ep4_in_ready = ep4_rdy_q;
`else
    logic unused_ep4;
    assign unused_ep4   = ^{ep4_in_data, ep4_in_valid};
    assign usb_flagb    = 1'b0;
    assign ep4_in_ready = 1'b0;
`endif

    // The bus follows the raw pins so the master sees data without synchronizer delay.
    always_comb begin
        fd_drv_en  = 1'b0;
        fd_drv_dat = ep2_head;
        if (rst_n && !usb_slcs && !usb_sloe) begin
            if (usb_fifoaddr == 2'b00)
                fd_drv_en = 1'b1;
`ifdef FX2_EMU_EP4_EN
            else if (usb_fifoaddr == 2'b01) begin
                fd_drv_en  = 1'b1;
                fd_drv_dat = ep4_head;
            end
`endif
        end
    end

    assign usb_fd = fd_drv_en ? fd_drv_dat : {DW{1'bz}};

    logic unused_sig;
    assign unused_sig = ^{sloe_q[1], ep6_cnt_nxt};
endmodule

// File: tb/tb_fx2_slave_fifo_emu.sv
module tb_fx2_slave_fifo_emu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  usb_fifoaddr;
    logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr;
    wire  [15:0] usb_fd;
    logic        m_drv;
    logic [15:0] m_dat;
    logic        usb_flaga, usb_flagb, usb_flagc;
    logic [15:0] ep2_in_data, ep4_in_data, ep6_out_data;
    logic        ep2_in_valid, ep2_in_ready, ep4_in_valid, ep4_in_ready;
    logic        ep6_out_valid, ep6_out_ready, ep2_underflow, ep6_overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain queues and sticky bits.
    logic [15:0] ep2_q[$];
    logic [15:0] ep6_q[$];
    logic [15:0] ep2_last;
    logic        ep2_uf, ep6_of;

    assign usb_fd = m_drv ? m_dat : 16'hzzzz;

    always #5 clk = ~clk;

    fx2_slave_fifo_emu #(.DW(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
        .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_fd(usb_fd),
        .usb_flaga(usb_flaga), .usb_flagb(usb_flagb), .usb_flagc(usb_flagc),
        .ep2_in_data(ep2_in_data), .ep2_in_valid(ep2_in_valid), .ep2_in_ready(ep2_in_ready),
        .ep4_in_data(ep4_in_data), .ep4_in_valid(ep4_in_valid), .ep4_in_ready(ep4_in_ready),
        .ep6_out_data(ep6_out_data), .ep6_out_valid(ep6_out_valid), .ep6_out_ready(ep6_out_ready),
        .ep2_underflow(ep2_underflow), .ep6_overflow(ep6_overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic h_push2(input logic [15:0] d);
        ep2_in_data  = d;
        ep2_in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (ep2_in_ready) break;
            tick(1);
        end
        chk("ep2_in_ready", ep2_in_ready, 1);
        if (ep2_in_ready) ep2_q.push_back(d);
        tick(1);
        ep2_in_valid = 1'b0;
    endtask

    // Master read at EP2; returns with slrd just released and cs still low.
    task automatic m_read(input logic [1:0] a_after, input string tag);
        logic [15:0] got, exp;
        usb_fifoaddr = 2'b00;
        usb_slcs = 1'b0;
        usb_sloe = 1'b0;
        tick(2);
        got = usb_fd;
        if (ep2_q.size() > 0) begin
            exp = ep2_q.pop_front();
            ep2_last = exp;
        end else begin
            exp = ep2_last;
            ep2_uf = 1'b1;
        end
        chk(tag, got, exp);
        usb_slrd = 1'b0;
        tick(4);
        usb_slrd = 1'b1;
        usb_sloe = 1'b1;
        usb_fifoaddr = a_after;
    endtask

    task automatic m_idle();
        tick(5);
        usb_slcs = 1'b1;
        usb_fifoaddr = 2'b00;
        tick(1);
    endtask

    task automatic m_write(input logic [1:0] a, input logic [15:0] d);
        usb_fifoaddr = a;
        usb_slcs = 1'b0;
        m_drv = 1'b1;
        m_dat = d;
        tick(1);
        usb_slwr = 1'b0;
        tick(4);
        usb_slwr = 1'b1;
        tick(5);
        m_drv = 1'b0;
        usb_slcs = 1'b1;
        tick(1);
        if (a == 2'b10) begin
            if (ep6_q.size() < 16) ep6_q.push_back(d);
            else ep6_of = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w, y1, y2;
        int n, lat;
        rst_n = 1'b0;
        usb_fifoaddr = 2'b00;
        usb_slcs = 1'b1; usb_sloe = 1'b1; usb_slrd = 1'b1; usb_slwr = 1'b1;
        m_drv = 1'b0; m_dat = '0;
        ep2_in_data = '0; ep2_in_valid = 1'b0;
        ep4_in_data = '0; ep4_in_valid = 1'b0;
        ep6_out_ready = 1'b0;
        ep2_last = '0; ep2_uf = 1'b0; ep6_of = 1'b0;
        tick(3);
        chk("rst_flaga", usb_flaga, 0);
        chk("rst_flagb", usb_flagb, 0);
        chk("rst_flagc", usb_flagc, 0);
        chk("rst_ep2_rdy", ep2_in_ready, 0);
        chk("rst_ep4_rdy", ep4_in_ready, 0);
        chk("rst_ep6_vld", ep6_out_valid, 0);
        chk("rst_uf", ep2_underflow, 0);
        chk("rst_of", ep6_overflow, 0);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_ep2_rdy", ep2_in_ready, 1);
        chk("post_rst_flagc", usb_flagc, 1);
        chk("post_rst_flagb", usb_flagb, 0);

        // Directed EP2 read pair and flag latency.
        h_push2(16'h1234);
        h_push2(16'hABCD);
        tick(2);
        chk("flaga_set", usb_flaga, 1);
        m_read(2'b00, "rd_1234");
        m_idle();
        m_read(2'b00, "rd_abcd");
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (!usb_flaga) begin lat = k; break; end
        end
        chk("flaga_clear_within_4", lat <= 4, 1);
        m_idle();
        chk("no_uf_yet", ep2_underflow, ep2_uf);

        // Bus release when not selected for output.
        w = 16'($urandom) | 16'h0001;
        h_push2(w);
        tick(2);
        usb_slcs = 1'b0; usb_sloe = 1'b1; m_drv = 1'b1; m_dat = '0;
        tick(1);
        chk("fd_release_oe_high", usb_fd, 0);
        usb_fifoaddr = 2'b10; usb_sloe = 1'b0;
        tick(1);
        chk("fd_release_ep6_addr", usb_fd, 0);
        m_drv = 1'b0; usb_fifoaddr = 2'b00;
        tick(1);
        chk("fd_head", usb_fd, ep2_q[0]);
        usb_sloe = 1'b1; usb_slcs = 1'b1;
        tick(1);

        // Random EP2 traffic.
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) h_push2(16'($urandom));
        for (int i = 0; i < 16 && ep2_q.size() > 0; i++) begin
            m_read(2'b00, "rd_rand");
            m_idle();
        end
        chk("flaga_drained", usb_flaga, 0);

        // Underflow: last word on the bus, pointers untouched.
        m_read(2'b00, "rd_empty_last");
        m_idle();
        chk("ep2_underflow", ep2_underflow, ep2_uf);
        chk("flaga_after_uf", usb_flaga, 0);
        h_push2(16'($urandom));
        m_read(2'b00, "rd_after_uf");
        m_idle();

        // EP6 held while not ready.
        m_write(2'b10, 16'h5A5A);
        chk("ep6_vld", ep6_out_valid, 1);
        chk("ep6_dat", ep6_out_data, ep6_q[0]);
        tick(3);
        chk("ep6_dat_held", ep6_out_data, 16'h5A5A);
        ep6_out_ready = 1'b1;
        tick(1);
        void'(ep6_q.pop_front());
        ep6_out_ready = 1'b0;
        chk("ep6_vld_drop", ep6_out_valid, 0);

        // Fill EP6, overflow, then drain with random backpressure.
        for (int i = 0; i < 16; i++) m_write(2'b10, 16'($urandom));
        tick(2);
        chk("flagc_full", usb_flagc, 0);
        chk("of_before", ep6_overflow, 0);
        m_write(2'b10, 16'($urandom));
        chk("of_after", ep6_overflow, ep6_of);
        chk("ep6_head_kept", ep6_out_data, ep6_q[0]);
        ep6_out_ready = 1'b1;
        tick(1);
        ep6_out_ready = 1'b0;
        void'(ep6_q.pop_front());
        tick(2);
        chk("flagc_after_pop", usb_flagc, 1);
        for (int k = 0; k < 200 && (ep6_q.size() > 0 || ep6_out_valid); k++) begin
            logic v, r;
            v = ep6_out_valid;
            chk("ep6_drain_vld", v, ep6_q.size() > 0);
            if (v && ep6_q.size() > 0) chk("ep6_drain_dat", ep6_out_data, ep6_q[0]);
            r = 1'($urandom);
            ep6_out_ready = r;
            tick(1);
            if (v && r && ep6_q.size() > 0) void'(ep6_q.pop_front());
        end
        ep6_out_ready = 1'b0;
        chk("ep6_drained", ep6_out_valid, 0);

        // Writes at addresses that are not sinks are ignored.
        m_write(2'b11, 16'($urandom));
        m_write(2'b01, 16'($urandom));
        chk("ep6_ignore_other_addr", ep6_out_valid, 0);
        chk("of_unchanged", ep6_overflow, ep6_of);

        // Address switches to EP6 in the slrd release clock: pop belongs to EP2.
        y1 = 16'($urandom);
        y2 = 16'($urandom);
        h_push2(y1);
        h_push2(y2);
        m_read(2'b10, "rd_addr_switch");
        m_idle();
        chk("switch_ep6_untouched", ep6_out_valid, 0);
        chk("switch_flaga", usb_flaga, 1);
        // Read strobe with cs high: no pop.
        usb_slrd = 1'b0;
        tick(4);
        usb_slrd = 1'b1;
        tick(5);
        // slrd and slwr low together at addr 00: the read is dropped.
        usb_slcs = 1'b0; m_drv = 1'b1; m_dat = 16'($urandom);
        usb_slrd = 1'b0; usb_slwr = 1'b0;
        tick(4);
        usb_slrd = 1'b1; usb_slwr = 1'b1;
        tick(5);
        m_drv = 1'b0; usb_slcs = 1'b1;
        tick(1);
        m_read(2'b00, "rd_y2");
        m_idle();
        chk("flaga_empty_again", usb_flaga, 0);

        // Reset in the middle of a write.
        h_push2(16'($urandom));
        m_write(2'b10, 16'($urandom));
        usb_fifoaddr = 2'b10; usb_slcs = 1'b0; m_drv = 1'b1; m_dat = 16'($urandom);
        usb_slwr = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_flaga", usb_flaga, 0);
        chk("midrst_ep6_vld", ep6_out_valid, 0);
        usb_slwr = 1'b1; m_drv = 1'b0; usb_slcs = 1'b1;
        tick(2);
        rst_n = 1'b1;
        chk("release_flaga", usb_flaga, 0);
        chk("release_flagc", usb_flagc, 0);
        ep2_q.delete();
        ep6_q.delete();
        ep2_last = '0; ep2_uf = 1'b0; ep6_of = 1'b0;
        tick(5);
        chk("post_midrst_ep6_vld", ep6_out_valid, 0);
        chk("post_midrst_flaga", usb_flaga, 0);
        chk("post_midrst_uf", ep2_underflow, 0);
        chk("post_midrst_of", ep6_overflow, 0);
        m_read(2'b00, "rd_after_reset");
        m_idle();
        chk("uf_after_reset_read", ep2_underflow, ep2_uf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
